// File: rtl/op_pkg.sv
// Shared definitions for the windowed operator family: sizing helpers,
// default kernel table and the operator FSM state type.
package op_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned num_w(input int unsigned pix_w, input int unsigned coef_w,
                                        input int unsigned k);
    return pix_w + coef_w + clog2(k * k);
  endfunction

  function automatic int unsigned den_w(input int unsigned coef_w, input int unsigned k);
    return coef_w + clog2(k * k);
  endfunction

  localparam int unsigned GAUSS5 [25] = '{2, 4,  5,  4, 2,
                                          4, 9,  12, 9, 4,
                                          5, 12, 15, 12, 5,
                                          4, 9,  12, 9, 4,
                                          2, 4,  5,  4, 2};

  // Gaussian (sum 159) for the 5x5 case, box kernel for every other size
  function automatic int unsigned default_coef(input int unsigned k, input int unsigned n);
    if (k == 5) return GAUSS5[n];
    return 1;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUM,
    S_DIV,
    S_OUT
  } op_state_t;

endpackage

// File: rtl/op_div_seq.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// A zero divisor yields a zero quotient.
module op_div_seq
  import op_pkg::*;
#(
  parameter int unsigned NW = 21,
  parameter int unsigned DW = 13
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          done,
  output logic [NW-1:0] quo
);

  localparam int unsigned CW = clog2(NW + 1);

  logic [NW-1:0] q_r;
  logic [DW-1:0] rem_r;
  logic [DW-1:0] d_r;
  logic          dz_r;
  logic          busy;
  logic [CW-1:0] cnt;

  // The start edge already retires the first quotient bit, so NW edges in total
  function automatic logic [DW+NW-1:0] step(input logic [DW-1:0] rem, input logic [NW-1:0] q,
                                            input logic [DW-1:0] d);
    logic [DW:0] sh;
    logic [DW:0] diff;
    sh   = {rem, q[NW-1]};
    diff = sh - {1'b0, d};
    if (sh >= {1'b0, d}) return {diff[DW-1:0], q[NW-2:0], 1'b1};
    return {sh[DW-1:0], q[NW-2:0], 1'b0};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      q_r   <= '0;
      rem_r <= '0;
      d_r   <= '0;
      dz_r  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      {rem_r, q_r} <= step('0, num, den);
      d_r          <= den;
      dz_r         <= (den == '0);
      cnt          <= CW'(NW - 1);
      busy         <= 1'b1;
      done         <= 1'b0;
    end else if (busy) begin
      {rem_r, q_r} <= step(rem_r, q_r, d_r);
      cnt          <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign quo = dz_r ? '0 : q_r;

endmodule

// File: rtl/op_conv_norm.sv
// KxK normalised convolution: border taps are dropped from both the weighted
// sum and the weight sum, then a sequential divide renormalises the result.
module op_conv_norm
  import op_pkg::*;
#(
  parameter int unsigned KSIZE      = 5,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned COEF_W     = 8,
  parameter int unsigned IMG_WIDTH  = 720,
  parameter int unsigned IMG_HEIGHT = 540
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [KSIZE*KSIZE*PIX_W-1:0]    in_data,
  input  logic [clog2(IMG_WIDTH)-1:0]     x,
  input  logic [clog2(IMG_HEIGHT)-1:0]    y,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PIX_W-1:0]                out_data,
  input  logic                            coef_we,
  input  logic [clog2(KSIZE*KSIZE)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]               coef_data,
  input  logic                            coef_commit
);

  localparam int unsigned KK    = KSIZE * KSIZE;
  localparam int unsigned H     = KSIZE / 2;
  localparam int unsigned XW    = clog2(IMG_WIDTH);
  localparam int unsigned YW    = clog2(IMG_HEIGHT);
  localparam int unsigned NUM_W = num_w(PIX_W, COEF_W, KSIZE);
  localparam int unsigned DEN_W = den_w(COEF_W, KSIZE);
  localparam logic [NUM_W-1:0] PIX_MAX = NUM_W'({PIX_W{1'b1}});

  op_state_t state;
  logic                  pending;
  logic [COEF_W-1:0]     shadow [KK];
  logic [COEF_W-1:0]     active [KK];
  logic [KK*PIX_W-1:0]   win_r;
  logic [XW-1:0]         x_r;
  logic [YW-1:0]         y_r;

  logic [NUM_W-1:0]      num_c;
  logic [DEN_W-1:0]      den_c;
  logic signed [XW+1:0]  col;
  logic signed [YW+1:0]  row;
  logic                  div_done;
  logic [NUM_W-1:0]      div_quo;

  assign in_ready = (state == S_IDLE) && !pending;

  always_comb begin
    num_c = '0;
    den_c = '0;
    col   = '0;
    row   = '0;
    for (int unsigned r = 0; r < KSIZE; r++) begin
      for (int unsigned c = 0; c < KSIZE; c++) begin
        col = $signed({2'b00, x_r}) + $signed((XW+2)'(c)) - $signed((XW+2)'(H));
        row = $signed({2'b00, y_r}) + $signed((YW+2)'(r)) - $signed((YW+2)'(H));
        if (col >= 0 && col < $signed((XW+2)'(IMG_WIDTH)) &&
            row >= 0 && row < $signed((YW+2)'(IMG_HEIGHT))) begin
          num_c = num_c + NUM_W'(win_r[(r*KSIZE+c)*PIX_W +: PIX_W]) * NUM_W'(active[r*KSIZE+c]);
          den_c = den_c + DEN_W'(active[r*KSIZE+c]);
        end
      end
    end
  end

  op_div_seq #(
    .NW(NUM_W),
    .DW(DEN_W)
  ) u_div (
    .clock (clock),
    .reset (reset),
    .start (state == S_SUM),
    .num   (num_c),
    .den   (den_c),
    .done  (div_done),
    .quo   (div_quo)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      pending   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      win_r     <= '0;
      x_r       <= '0;
      y_r       <= '0;
      for (int unsigned i = 0; i < KK; i++) begin
        shadow[i] <= COEF_W'(default_coef(KSIZE, i));
        active[i] <= COEF_W'(default_coef(KSIZE, i));
      end
    end else begin
      if (coef_we && (32'(coef_addr) < KK)) shadow[coef_addr] <= coef_data;
      // Bank swap only between transactions; a commit on the copy edge re-arms
      if (state == S_IDLE && pending) active <= shadow;
      pending <= coef_commit || (pending && state != S_IDLE);

      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            win_r <= in_data;
            x_r   <= x;
            y_r   <= y;
            state <= S_SUM;
          end
        end
        S_SUM: state <= S_DIV;
        S_DIV: begin
          if (div_done) begin
            out_data  <= (div_quo > PIX_MAX) ? '1 : div_quo[PIX_W-1:0];
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_op_conv_norm.sv
// Directed bench for op_conv_norm: a reference model computes each expected
// pixel at acceptance and a scoreboard compares it on every output transfer.
module tb_op_conv_norm;

  localparam int K     = 5;
  localparam int KK    = 25;
  localparam int NUM_W = 21;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [KK*8-1:0]   in_data = '0;
  logic [9:0]        x = '0;
  logic [9:0]        y = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [7:0]        out_data;
  logic              coef_we = 1'b0;
  logic [4:0]        coef_addr = '0;
  logic [7:0]        coef_data = '0;
  logic              coef_commit = 1'b0;

  int checks = 0;
  int errors = 0;
  int sb [$];
  int tb_coef [KK];
  int gauss [KK] = '{2, 4, 5, 4, 2, 4, 9, 12, 9, 4, 5, 12, 15, 12, 5,
                     4, 9, 12, 9, 4, 2, 4, 5, 4, 2};

  op_conv_norm #(
    .KSIZE(5), .PIX_W(8), .COEF_W(8), .IMG_WIDTH(720), .IMG_HEIGHT(540)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_commit(coef_commit)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int model(input logic [KK*8-1:0] w, input int xx, input int yy);
    int num, den, col, row, q;
    num = 0;
    den = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        col = xx + c - 2;
        row = yy + r - 2;
        if (col >= 0 && col < 720 && row >= 0 && row < 540) begin
          num += int'(w[(r*K+c)*8 +: 8]) * tb_coef[r*K+c];
          den += tb_coef[r*K+c];
        end
      end
    if (den == 0) return 0;
    q = num / den;
    return (q > 255) ? 255 : q;
  endfunction

  function automatic logic [KK*8-1:0] uniform(input int v);
    logic [KK*8-1:0] w;
    for (int i = 0; i < KK; i++) w[i*8 +: 8] = 8'(v);
    return w;
  endfunction

  function automatic logic [KK*8-1:0] rand_win();
    logic [KK*8-1:0] w;
    for (int i = 0; i < KK; i++) w[i*8 +: 8] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [KK*8-1:0] w, input int xx, input int yy, input bit push);
    bit ok;
    ok = 1'b0;
    in_data  = w;
    x        = 10'(xx);
    y        = 10'(yy);
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      @(posedge clock);
      if (push) sb.push_back(model(w, xx, yy));
      #1;
    end else begin
      chk("accept_timeout", 32'(ok), 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic write_shadow(input int v);
    for (int i = 0; i < KK; i++) begin
      coef_we   = 1'b1;
      coef_addr = 5'(i);
      coef_data = 8'(v);
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
      else chk("out_data", 32'(out_data), 32'(sb.pop_front()));
    end
  end

  initial begin
    int n;
    int held;
    bit saw;
    for (int i = 0; i < KK; i++) tb_coef[i] = gauss[i];

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Uniform interior window; the accepting edge counts as edge 1
    send(uniform(100), 100, 100, 1'b1);
    n = 1;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(NUM_W + 2));
    chk("uniform100", 32'(out_data), 32'd100);
    drain();

    send(uniform(200), 0, 0, 1'b1);
    drain();
    send(uniform(200), 719, 539, 1'b1);
    drain();

    begin
      logic [KK*8-1:0] imp;
      imp = '0;
      imp[12*8 +: 8] = 8'd255;
      send(imp, 300, 200, 1'b1);
      drain();
      chk("impulse_24", 32'(model(imp, 300, 200)), 32'(out_data));
    end

    send(rand_win(), 360, 270, 1'b1);
    drain();
    send(rand_win(), 1, 538, 1'b1);
    drain();

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    send(uniform(77), 10, 10, 1'b1);
    for (int i = 0; i < 100 && !out_valid; i++) tick();
    held = int'(out_data);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_data", 32'(out_data), 32'(held));
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("post_xfer_valid", 32'(out_valid), 32'd0);
    chk("post_xfer_in_ready", 32'(in_ready), 32'd1);
    chk("post_xfer_sb", 32'(sb.size()), 32'd0);

    write_shadow(0);
    coef_we = 1'b1; coef_addr = 5'd31; coef_data = 8'd99;
    tick();
    coef_we = 1'b0;
    commit();
    for (int i = 0; i < KK; i++) tb_coef[i] = 0;
    send(uniform(100), 50, 50, 1'b1);
    drain();

    write_shadow(1);
    send(rand_win(), 200, 100, 1'b1);
    repeat (5) tick();
    commit();
    for (int i = 0; i < KK; i++) tb_coef[i] = 1;
    send(rand_win(), 400, 300, 1'b1);
    drain();
    send(rand_win(), 0, 0, 1'b1);
    drain();

    // Abort mid-divide: nothing may emerge, and the banks return to defaults
    send(uniform(60), 100, 100, 1'b0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < KK; i++) tb_coef[i] = gauss[i];
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) saw = 1'b1;
    end
    chk("abort_no_output", 32'(saw), 32'd0);
    send(uniform(50), 100, 100, 1'b1);
    drain();
    send(rand_win(), 718, 2, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
